inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the 64-word instruction memory. Accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit word.
- Writes each word into the instruction file at consecutive word addresses, starting at 0.
- Holds the CPU (cpu_hold) while loading. Signals completion or error when the load ends.
- Sits between the host byte source (UART/testbench) and the instruction memory's write port.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction file.
- ADDR_W, 6, width of mem_addr; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle; a transfer happens when in_valid && in_ready.
- mem_we  output  1  one-cycle write strobe to the instruction file.
- mem_addr  output  ADDR_W  word index being written.
- mem_wdata  output  32  word being written.
- cpu_hold  output  1  keeps the CPU/PC stalled while high.
- busy  output  1  load in progress.
- done  output  1  load finished; held until next start or reset.
- err  output  1  load aborted or failed; held until next start or reset.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0. Internal byte counter=0, word count register=0.
- Reset mid-load discards all progress. Words already written stay in memory.
- States and transitions:
  - IDLE: wait for start. On start go to LEN; clear done/err; set busy=1, cpu_hold=1, mem_addr=0.
  - LEN: in_ready=1. The first accepted byte is N, the number of words.
    - N==0 or N>DEPTH: set err=1, go to DONE. No writes occur.
    - Otherwise store N and go to BYTES.
  - BYTES: in_ready=1. Accepted bytes are packed big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0]. After the 4th accepted byte, go to WRITE.
  - WRITE: in_ready=0. mem_we=1 for exactly one cycle, with mem_addr and mem_wdata stable during it.
    - If mem_addr==N-1, go to DONE (CHK when CHECKSUM_EN is defined).
    - Otherwise increment mem_addr, clear the byte counter, return to BYTES.
  - DONE: busy=0, done=1, cpu_hold=0, in_ready=0. A new start re-enters LEN as described for IDLE.
- Latency: the mem_we cycle immediately follows the cycle that accepts the 4th byte of a word.
- in_ready drops for one cycle per word because of WRITE. A source holding in_valid high stalls exactly one cycle per word.
- The 4th byte of word k and the mem_we for word k never share a cycle. At most one byte is accepted per cycle.
- mem_addr never exceeds N-1 and never wraps. An N==DEPTH load ends with mem_addr=DEPTH-1.
- start during LEN/BYTES/WRITE/CHK is ignored.
- in_valid while in_ready=0 is not consumed.
- Bytes arriving after DONE are not accepted.
- cpu_hold is 1 from reset until the first DONE, and 1 again from any start until DONE.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, enter CHK with in_ready=1. Accept one trailer byte and compare it with the XOR of all 4*N data bytes (length byte excluded).
  - Mismatch: err=1. done=1 and cpu_hold=0 still follow. Memory contents are not rolled back.
  - Then go to DONE.
- Undefined: no CHK state, no trailer byte. The load ends at DONE after the final write, and err can only come from a bad length.

Test Plan:
- Reset asserted mid-BYTES after 2 bytes -> all outputs at reset values on the next edge with no mem_we. A following start plus a full stream loads correctly from addr 0.
- start; stream 0x02,12,34,56,78,9A,BC,DE,F0 with in_valid held high -> mem_we at addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0. in_ready=0 exactly in those two cycles. done=1, cpu_hold=0, err=0.
- Length byte 0x00, and separately 0x41 (65) -> err=1, done=1, no mem_we pulses, in_ready=0 afterwards.
- N=64 with data = word index -> 64 writes, addresses 0..63 in order, last mem_addr=63, done=1.
- in_valid toggled randomly, plus a start pulse mid-load -> same write sequence as back-to-back streaming; the stray start has no effect.
- With INST_LOADER_CHECKSUM_EN and N=1, data 01,02,03,04: trailer 0x04 -> err=0; trailer 0x05 -> err=1. In both cases mem_we writes 0x01020304 at addr 0.

Source files
------------

// File: rtl/inst_loader_if.sv
// Byte-stream handshake plus instruction-file write port of the instruction loader.
// The loader uses the slave view; the host/byte source uses the master view.
interface inst_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: packs a length-prefixed byte stream into big-endian 32-bit words and writes
// them to the instruction file from word 0 upward. Trailer checksum: INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_BYTES = 3'd2,
    ST_WRITE = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [1:0]        cnt_r;
  logic [23:0]       word_r;
  logic [ADDR_W-1:0] last_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              we_r;
  logic              ready_r;
  logic              hold_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              accept_s;
  logic              len_bad_s;
  logic              last_s;
  logic              start_ok_s;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_r;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept_s   = bus.in_valid && ready_r;
  assign len_bad_s  = (bus.in_data == 8'd0) || (bus.in_data > DEPTH_B);
  assign last_s     = (addr_r == last_r);
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  assign bus.in_ready  = ready_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign cpu_hold      = hold_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s = ST_LEN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          state_nx_s = len_bad_s ? ST_DONE : ST_BYTES;
        end else begin
          state_nx_s = ST_LEN;
        end
      end
      ST_BYTES: begin
        if (accept_s && (cnt_r == 2'd3)) begin
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_BYTES;
        end
      end
      ST_WRITE: begin
        if (last_s) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_nx_s = ST_CHK;
`else
          state_nx_s = ST_DONE;
`endif
        end else begin
          state_nx_s = ST_BYTES;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_CHK;
        end
      end
`endif
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Status and strobe outputs are registered decodes of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      hold_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
`ifdef INST_LOADER_CHECKSUM_EN
      ready_r <= (state_nx_s == ST_LEN) || (state_nx_s == ST_BYTES) || (state_nx_s == ST_CHK);
`else
      ready_r <= (state_nx_s == ST_LEN) || (state_nx_s == ST_BYTES);
`endif
      we_r    <= (state_nx_s == ST_WRITE);
      hold_r  <= (state_nx_s != ST_DONE);
      busy_r  <= (state_nx_s != ST_DONE) && (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // Byte packing, address sequencing and checksum accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= 2'd0;
      word_r  <= 24'd0;
      last_r  <= '0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_r  <= 8'd0;
`endif
    end else if (start_ok_s) begin
      cnt_r  <= 2'd0;
      addr_r <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_LEN: begin
          if (accept_s && !len_bad_s) begin
            last_r <= ADDR_W'(bus.in_data - 8'd1);
          end
        end
        ST_BYTES: begin
          if (accept_s) begin
            cnt_r  <= cnt_r + 2'd1;
            word_r <= {word_r[15:0], bus.in_data};
`ifdef INST_LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, bus.in_data);
`endif
            if (cnt_r == 2'd3) begin
              wdata_r <= {word_r, bus.in_data};
            end
          end
        end
        ST_WRITE: begin
          // The last index is never incremented past, so mem_addr cannot wrap.
          if (!last_s) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_r  <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Error flag: bad length, or trailer mismatch when the checksum is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_LEN) && accept_s && len_bad_s) begin
      err_r <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
    end else if ((state_r == ST_CHK) && accept_s && (bus.in_data != csum_r)) begin
      err_r <= 1'b1;
`endif
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal loads, bad lengths, mid-load reset, stalls,
// stray start and (when INST_LOADER_CHECKSUM_EN is defined) the trailer checksum.
module tb_inst_loader;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  logic start;
  logic cpu_hold;
  logic busy;
  logic done;
  logic err;

  inst_loader_if #(.ADDR_W(6)) bus ();

  inst_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int          n_vec;
  int          n_miscmp;
  int          stall_cnt;
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  dat_q[$];
  logic [7:0]  tx_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port and stall monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (busy && !bus.in_ready) stall_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_bus();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    if (!got) check_val("accept_timeout", 32'(got), 32'd1);
    tick();
  endtask

  task automatic wait_done(input string tag);
    for (int t = 0; t < 1000 && !done; t++) @(negedge clk);
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_flags"}, 32'({bus.in_ready, bus.mem_we, cpu_hold, busy, done, err}), 32'b001000);
    check_val({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check_val({tag, "_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  // Sends length + dat_q (+ trailer); rnd inserts idle gaps and one stray start.
  task automatic run_load(input logic [7:0] n, input bit rnd, input bit bad_trl, input string tag);
    int         base;
    int         st0;
    int         gap;
    logic [7:0] x;
    logic [31:0] exp_w;
    tx_q.delete();
    tx_q.push_back(n);
    x = 8'h00;
    foreach (dat_q[i]) begin
      tx_q.push_back(dat_q[i]);
      x = x ^ dat_q[i];
    end
    if (CHK_EN) tx_q.push_back(bad_trl ? (x ^ 8'h01) : x);
    base = wr_addr_q.size();
    st0  = stall_cnt;
    pulse_start();
    check_val({tag, "_startclr"}, 32'({done, err, busy, cpu_hold}), 32'b0011);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (rnd) begin
        gap = $urandom_range(0, 2);
        idle_bus();
        repeat (gap) tick();
        if (i == 5) pulse_start();
      end
      send_byte(tx_q[i]);
    end
    idle_bus();
    wait_done({tag, "_done"});
    check_val({tag, "_nwr"}, 32'(wr_addr_q.size() - base), 32'(n));
    for (int k = 0; k < int'(n); k++) begin
      exp_w = {dat_q[4*k], dat_q[4*k+1], dat_q[4*k+2], dat_q[4*k+3]};
      if (base + k < wr_addr_q.size()) begin
        check_val($sformatf("%s_addr%0d", tag, k), 32'(wr_addr_q[base+k]), 32'(k));
        check_val($sformatf("%s_data%0d", tag, k), wr_data_q[base+k], exp_w);
      end
    end
    check_val({tag, "_stalls"}, 32'(stall_cnt - st0), 32'(n));
    check_val({tag, "_flags"}, 32'({bus.in_ready, cpu_hold, busy, err}), 32'({3'b000, bad_trl & CHK_EN}));
    check_val({tag, "_lastaddr"}, 32'(bus.mem_addr), 32'(n) - 32'd1);
  endtask

  task automatic run_badlen(input logic [7:0] n, input string tag);
    int base;
    base = wr_addr_q.size();
    pulse_start();
    send_byte(n);
    idle_bus();
    wait_done({tag, "_done"});
    check_val({tag, "_flags"}, 32'({bus.in_ready, cpu_hold, busy, err}), 32'b0001);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) tick();
    check_val({tag, "_post_ready"}, 32'({bus.in_ready, done}), 32'b01);
    idle_bus();
    check_val({tag, "_nwr"}, 32'(wr_addr_q.size() - base), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    reset    = 1'b1;
    start    = 1'b0;
    idle_bus();
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();
    check_reset_vals("post_reset");

    dat_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(8'd2, 1'b0, 1'b0, "basic");

    // Reset after the length byte and two data bytes.
    begin
      int base;
      base = wr_addr_q.size();
      pulse_start();
      send_byte(8'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      idle_bus();
      reset = 1'b1;
      #2;
      check_reset_vals("midreset");
      tick();
      reset = 1'b0;
      tick();
      check_val("midreset_nwr", 32'(wr_addr_q.size() - base), 32'd0);
    end
    dat_q = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_load(8'd1, 1'b0, 1'b0, "reload");

    run_badlen(8'h00, "len0");
    run_badlen(8'h41, "len65");

    dat_q.delete();
    for (int k = 0; k < 64; k++) begin
      dat_q.push_back(8'h00);
      dat_q.push_back(8'h00);
      dat_q.push_back(8'h00);
      dat_q.push_back(8'(k));
    end
    run_load(8'd64, 1'b0, 1'b0, "full64");

    dat_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_load(8'd3, 1'b1, 1'b0, "gappy");

`ifdef INST_LOADER_CHECKSUM_EN
    dat_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(8'd1, 1'b0, 1'b0, "csum_ok");
    run_load(8'd1, 1'b0, 1'b1, "csum_bad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
